batrider_cen_sched: RTL and testbench

- Runtime-programmable scheduler for the Batrider clock-enable tree.
- Generates NCH fractional clock enables (CEN/CENB pairs) off CLK96, plus one half-rate enable derived from a chosen channel (YM2151 style).
- Accepts per-channel n/m reconfiguration through a valid/ready port and applies it only at a safe period boundary.
- Provides a global pause and single-step for debug and menu freeze.

---
 rtl/batrider_cen_pkg.sv | 33 +++
 rtl/batrider_cen_chan.sv | 63 ++++++
 rtl/batrider_cen_sched.sv | 123 ++++++++++++
 tb/tb_batrider_cen_sched.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/batrider_cen_pkg.sv
// Shared types, defaults and config validity rule for the Batrider clock-enable scheduler.
package batrider_cen_pkg;

  localparam int NCH = 6;
  localparam int W   = 10;

  localparam int CH_YM    = 0;
  localparam int CH_GP    = 1;
  localparam int CH_GP2X  = 2;
  localparam int CH_Z80   = 3;
  localparam int CH_OKI   = 4;
  localparam int CH_SPARE = 5;

  typedef logic [W-1:0] nm_t;

  // Indexed by the CH_* constants above; the spare channel powers up disabled.
  localparam nm_t DEF_N [NCH] = '{10'd1,  10'd9,   10'd9,  10'd1,  10'd1,  10'd0};
  localparam nm_t DEF_M [NCH] = '{10'd24, 10'd128, 10'd64, 10'd18, 10'd30, 10'd1};

  typedef struct packed {
    logic [2:0] ch;
    nm_t        n;
    nm_t        m;
  } cfg_t;

  function automatic logic cfg_is_valid(input cfg_t c);
    logic [W:0] two_n;
    two_n = {c.n, 1'b0};
    return (int'(c.ch) < NCH) &&
           ((c.n == '0) || ((c.m >= nm_t'(2)) && (two_n <= {1'b0, c.m})));
  endfunction

endpackage

// File: rtl/batrider_cen_chan.sv
// One fractional n/m clock-enable channel: accumulator plus registered CEN/CENB pulses.
module batrider_cen_chan
  import batrider_cen_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] n,
  input  logic [W-1:0] m,
  input  logic         advance,
  input  logic         load_zero,
  output logic         wrap,
  output logic         cen,
  output logic         cenb
);

  logic [W:0] acc_q, acc_d;
  logic [W:0] sum, half;
  logic       cen_q, cen_d;
  logic       cenb_q, cenb_d;

  // wrap is exposed so the parent can land a reconfiguration exactly on a period boundary.
  always_comb begin
    sum    = acc_q + {1'b0, n};
    half   = {2'b00, m[W-1:1]};
    acc_d  = acc_q;
    cen_d  = 1'b0;
    cenb_d = 1'b0;
    wrap   = 1'b0;
    if (n == '0) begin
      acc_d = '0;
    end else if (advance) begin
      if (sum >= {1'b0, m}) begin
        wrap  = 1'b1;
        cen_d = 1'b1;
        acc_d = sum - {1'b0, m};
      end else begin
        acc_d = sum;
        if ((acc_q < half) && (sum >= half)) begin
          cenb_d = 1'b1;
        end
      end
    end
    if (load_zero) begin
      acc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      cen_q  <= 1'b0;
      cenb_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cen_q  <= cen_d;
      cenb_q <= cenb_d;
    end
  end

  assign cen  = cen_q;
  assign cenb = cenb_q;

endmodule

// File: rtl/batrider_cen_sched.sv
// Batrider clock-enable scheduler: NCH fractional channels, half-rate CEN_DIV,
// a one-deep shadow slot for runtime n/m updates, and global pause/step.
module batrider_cen_sched
  import batrider_cen_pkg::*;
#(
  parameter int DIV_SRC = CH_YM
)
(
  input  logic           CLK96,
  input  logic           RESET_N,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [2:0]     cfg_ch,
  input  logic [W-1:0]   cfg_n,
  input  logic [W-1:0]   cfg_m,
  output logic           cfg_err,
  input  logic           pause,
  input  logic           step,
  output logic [NCH-1:0] CEN,
  output logic [NCH-1:0] CENB,
  output logic           CEN_DIV
);

  nm_t            n_q [NCH];
  nm_t            n_d [NCH];
  nm_t            m_q [NCH];
  nm_t            m_d [NCH];
  cfg_t           pend_q, pend_d;
  logic           pend_vld_q, pend_vld_d;
  logic           ready_q, ready_d;
  logic           err_q, err_d;
  logic           phase_q, phase_d;
  logic           div_q, div_d;

  cfg_t           req;
  logic           active, xfer, req_ok, apply;
  logic [NCH-1:0] wrap, load_zero;

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    batrider_cen_chan u_chan (
      .clk       (CLK96),
      .rst_n     (RESET_N),
      .n         (n_q[g]),
      .m         (m_q[g]),
      .advance   (active),
      .load_zero (load_zero[g]),
      .wrap      (wrap[g]),
      .cen       (CEN[g]),
      .cenb      (CENB[g])
    );
  end

  // An idle target or a shutdown applies at once; otherwise wait for the target's wrap
  // so the running period finishes with its old n/m.
  always_comb begin
    active    = !pause || step;
    req.ch    = cfg_ch;
    req.n     = cfg_n;
    req.m     = cfg_m;
    req_ok    = cfg_is_valid(req);
    xfer      = cfg_valid && ready_q;
    apply     = 1'b0;
    load_zero = '0;
    for (int i = 0; i < NCH; i++) begin
      n_d[i] = n_q[i];
      m_d[i] = m_q[i];
      if (pend_vld_q && active && (pend_q.ch == 3'(i)) &&
          ((n_q[i] == '0) || (pend_q.n == '0) || wrap[i])) begin
        apply        = 1'b1;
        load_zero[i] = 1'b1;
        n_d[i]       = pend_q.n;
        m_d[i]       = pend_q.m;
      end
    end
  end

  always_comb begin
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (apply) begin
      pend_vld_d = 1'b0;
    end
    if (xfer && req_ok) begin
      pend_d     = req;
      pend_vld_d = 1'b1;
    end
    ready_d = !pend_vld_q && !(xfer && req_ok);
    err_d   = xfer && !req_ok;
    phase_d = phase_q ^ wrap[DIV_SRC];
    div_d   = wrap[DIV_SRC] && phase_q;
  end

  always_ff @(posedge CLK96 or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < NCH; i++) begin
        n_q[i] <= DEF_N[i];
        m_q[i] <= DEF_M[i];
      end
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      ready_q    <= 1'b1;
      err_q      <= 1'b0;
      phase_q    <= 1'b0;
      div_q      <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        n_q[i] <= n_d[i];
        m_q[i] <= m_d[i];
      end
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      phase_q    <= phase_d;
      div_q      <= div_d;
    end
  end

  assign cfg_ready = ready_q;
  assign cfg_err   = err_q;
  assign CEN_DIV   = div_q;

endmodule

// File: tb/tb_batrider_cen_sched.sv
// Self-checking bench for batrider_cen_sched: directed tables, corner sequences and a
// randomized run, all compared every cycle against a behavioural model.
module tb_batrider_cen_sched;
  import batrider_cen_pkg::*;

  localparam int DIV = 0;

  logic           CLK96 = 1'b0;
  logic           RESET_N = 1'b1;
  logic           cfg_valid = 1'b0;
  logic           cfg_ready;
  logic [2:0]     cfg_ch = '0;
  logic [W-1:0]   cfg_n = '0;
  logic [W-1:0]   cfg_m = '0;
  logic           cfg_err;
  logic           pause = 1'b0;
  logic           step = 1'b0;
  logic [NCH-1:0] CEN, CENB;
  logic           CEN_DIV;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  batrider_cen_sched #(.DIV_SRC(DIV)) dut (
    .CLK96     (CLK96),
    .RESET_N   (RESET_N),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_n     (cfg_n),
    .cfg_m     (cfg_m),
    .cfg_err   (cfg_err),
    .pause     (pause),
    .step      (step),
    .CEN       (CEN),
    .CENB      (CENB),
    .CEN_DIV   (CEN_DIV)
  );

  always #5 CLK96 = ~CLK96;

  // Behavioural reference: integer accumulators, a single pending slot and a div phase bit.
  int             md_acc [NCH];
  int             md_n [NCH];
  int             md_m [NCH];
  int             def_n [NCH] = '{1, 9, 9, 1, 1, 0};
  int             def_m [NCH] = '{24, 128, 64, 18, 30, 1};
  bit             md_pend, md_phase;
  int             md_pch, md_pn, md_pm;
  logic [NCH-1:0] ex_cen, ex_cenb;
  logic           ex_div, ex_err, ex_ready;

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      md_acc[i] = 0;
      md_n[i]   = def_n[i];
      md_m[i]   = def_m[i];
    end
    md_pend  = 0;
    md_phase = 0;
    ex_cen   = '0;
    ex_cenb  = '0;
    ex_div   = 0;
    ex_err   = 0;
    ex_ready = 1;
  endtask

  task automatic model_edge();
    bit act, was_pend, xfer, ok;
    bit wr [NCH];
    int s, cn, cm, cc;
    act      = !pause || step;
    was_pend = md_pend;
    ex_cen   = '0;
    ex_cenb  = '0;
    ex_div   = 0;
    ex_err   = 0;
    for (int i = 0; i < NCH; i++) begin
      wr[i] = 0;
      if (act && md_n[i] != 0) begin
        s = md_acc[i] + md_n[i];
        if (s >= md_m[i]) begin
          wr[i]     = 1;
          ex_cen[i] = 1'b1;
          md_acc[i] = s - md_m[i];
        end else begin
          if (md_acc[i] < md_m[i] / 2 && s >= md_m[i] / 2) ex_cenb[i] = 1'b1;
          md_acc[i] = s;
        end
      end
    end
    if (md_pend && act && (md_n[md_pch] == 0 || md_pn == 0 || wr[md_pch])) begin
      md_n[md_pch]   = md_pn;
      md_m[md_pch]   = md_pm;
      md_acc[md_pch] = 0;
      md_pend        = 0;
    end
    if (wr[DIV]) begin
      ex_div   = md_phase;
      md_phase = !md_phase;
    end
    cn   = int'(cfg_n);
    cm   = int'(cfg_m);
    cc   = int'(cfg_ch);
    xfer = cfg_valid && ex_ready;
    ok   = (cc < NCH) && ((cn == 0) || (cm >= 2 && 2 * cn <= cm));
    if (xfer && ok) begin
      md_pend = 1;
      md_pch  = cc;
      md_pn   = cn;
      md_pm   = cm;
    end
    ex_err   = xfer && !ok;
    ex_ready = !was_pend && !(xfer && ok);
  endtask

  always @(posedge CLK96 or negedge RESET_N) begin
    if (!RESET_N) begin
      model_reset();
      cyc = 0;
    end else begin
      model_edge();
      cyc = cyc + 1;
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge CLK96) begin
    if (chk_en) begin
      checkOutput("model", int'({CEN, CENB, CEN_DIV, cfg_ready, cfg_err}),
                  int'({ex_cen, ex_cenb, ex_div, ex_ready, ex_err}));
    end
  end

  typedef struct {
    int cyc;
    int sig;
    int idx;
    bit exp;
  } tl_t;

  typedef struct {
    logic [2:0] ch;
    int         n;
    int         m;
    bit         exp_err;
    bit         exp_ready;
  } cfg_vec_t;

  tl_t      tl [$];
  cfg_vec_t cv [$];

  function automatic int get_sig(input int sig, input int idx);
    case (sig)
      0:       return int'(CEN[idx]);
      1:       return int'(CENB[idx]);
      2:       return int'(CEN_DIV);
      3:       return int'(cfg_ready);
      default: return int'(cfg_err);
    endcase
  endfunction

  task automatic addTl(input int c, input int s, input int i, input bit e);
    tl_t t;
    t.cyc = c;
    t.sig = s;
    t.idx = i;
    t.exp = e;
    tl.push_back(t);
  endtask

  task automatic to_cycle(input int k);
    int guard = 0;
    while (cyc < k && guard < 20000) begin
      @(negedge CLK96);
      guard++;
    end
    if (cyc != k) checkOutput($sformatf("reach_cycle_%0d", k), cyc, k);
  endtask

  task automatic runTimeline(input string tag);
    foreach (tl[i]) begin
      to_cycle(tl[i].cyc);
      checkOutput($sformatf("%s_c%0d_s%0d_i%0d", tag, tl[i].cyc, tl[i].sig, tl[i].idx),
                  get_sig(tl[i].sig, tl[i].idx), int'(tl[i].exp));
    end
    tl.delete();
  endtask

  task automatic do_reset();
    #1;
    RESET_N   = 1'b0;
    cfg_valid = 1'b0;
    pause     = 1'b0;
    step      = 1'b0;
    @(negedge CLK96);
    RESET_N = 1'b1;
  endtask

  task automatic applyStimulus(input logic [2:0] ch, input int n, input int m);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_n     = W'(n);
    cfg_m     = W'(m);
    @(negedge CLK96);
    cfg_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt1, adj, pulses, r, d;
    bit prev1;

    @(negedge CLK96);
    do_reset();
    chk_en = 1'b1;

    // Default schedule from reset.
    cnt1  = 0;
    adj   = 0;
    prev1 = 0;
    for (int c = 1; c <= 130; c++) begin
      to_cycle(c);
      checkOutput("t1_cen0", int'(CEN[0]), int'(c % 24 == 0));
      checkOutput("t1_cenb0", int'(CENB[0]), int'(c % 24 == 12));
      checkOutput("t1_div", int'(CEN_DIV), int'(c % 48 == 0));
      if (c <= 128) begin
        if (CEN[1]) cnt1++;
        if (CEN[1] && prev1) adj++;
        prev1 = CEN[1];
      end
    end
    checkOutput("t1_cen1_count", cnt1, 9);
    checkOutput("t1_cen1_adjacent", adj, 0);

    // Reconfigure ch3 mid-period; old period completes before the new rate takes over.
    do_reset();
    to_cycle(5);
    applyStimulus(3'd3, 1, 12);
    addTl(6, 3, 0, 0);
    addTl(17, 0, 3, 0);
    addTl(18, 0, 3, 1);
    addTl(18, 3, 0, 0);
    addTl(19, 3, 0, 1);
    addTl(29, 0, 3, 0);
    addTl(30, 0, 3, 1);
    addTl(42, 0, 3, 1);
    runTimeline("t2");

    // Invalid configs are rejected without disturbing anything.
    do_reset();
    cv.push_back('{ch: 3'd0, n: 5, m: 8, exp_err: 1'b1, exp_ready: 1'b1});
    cv.push_back('{ch: 3'd7, n: 1, m: 12, exp_err: 1'b1, exp_ready: 1'b1});
    cv.push_back('{ch: 3'd6, n: 0, m: 1, exp_err: 1'b1, exp_ready: 1'b1});
    cv.push_back('{ch: 3'd1, n: 2, m: 1, exp_err: 1'b1, exp_ready: 1'b1});
    cv.push_back('{ch: 3'd5, n: 1, m: 4, exp_err: 1'b0, exp_ready: 1'b0});
    to_cycle(3);
    foreach (cv[i]) begin
      applyStimulus(cv[i].ch, cv[i].n, cv[i].m);
      checkOutput($sformatf("t3_err_%0d", i), int'(cfg_err), int'(cv[i].exp_err));
      checkOutput($sformatf("t3_ready_%0d", i), int'(cfg_ready), int'(cv[i].exp_ready));
      @(negedge CLK96);
      checkOutput($sformatf("t3_err_clear_%0d", i), int'(cfg_err), 0);
    end
    for (int c = cyc; c <= 50; c++) begin
      to_cycle(c);
      checkOutput("t3_cen0", int'(CEN[0]), int'(c % 24 == 0));
    end

    // Pause freezes everything; steps advance one cycle each; resume keeps phase.
    do_reset();
    to_cycle(10);
    pause  = 1'b1;
    pulses = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK96);
      if ((|CEN) || (|CENB) || CEN_DIV) pulses++;
    end
    checkOutput("t4_paused_pulses", pulses, 0);
    for (int k = 1; k <= 14; k++) begin
      step = 1'b1;
      @(negedge CLK96);
      checkOutput($sformatf("t4_step_%0d", k), int'(CEN[0]), int'(k == 14));
      step = 1'b0;
      @(negedge CLK96);
    end
    pause = 1'b0;
    r     = cyc;
    d     = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK96);
      if (CEN[0]) begin
        d = cyc - r;
        break;
      end
    end
    checkOutput("t4_resume_gap", d, 24);

    // Enable the spare channel, then shut it down again.
    do_reset();
    to_cycle(3);
    applyStimulus(3'd5, 1, 4);
    addTl(4, 3, 0, 0);
    addTl(5, 3, 0, 0);
    addTl(6, 3, 0, 1);
    addTl(8, 0, 5, 0);
    addTl(9, 0, 5, 1);
    addTl(10, 0, 5, 0);
    addTl(13, 0, 5, 1);
    addTl(17, 0, 5, 1);
    runTimeline("t5");
    to_cycle(20);
    applyStimulus(3'd5, 0, 1);
    to_cycle(23);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK96);
      if (CEN[5] || CENB[5]) pulses++;
    end
    checkOutput("t5_silent", pulses, 0);

    // Reset while an update is pending and a pulse is high.
    do_reset();
    to_cycle(5);
    applyStimulus(3'd0, 1, 10);
    to_cycle(12);
    checkOutput("t6_pre_cenb0", int'(CENB[0]), 1);
    #1;
    RESET_N = 1'b0;
    #1;
    checkOutput("t6_async_outs", int'({CEN, CENB, CEN_DIV, cfg_err}), 0);
    checkOutput("t6_async_ready", int'(cfg_ready), 1);
    @(negedge CLK96);
    RESET_N = 1'b1;
    addTl(10, 0, 0, 0);
    addTl(12, 1, 0, 1);
    addTl(23, 0, 0, 0);
    addTl(24, 0, 0, 1);
    addTl(34, 0, 0, 0);
    addTl(48, 0, 0, 1);
    runTimeline("t6");

    // Randomized traffic against the model.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      int m;
      m         = int'($urandom_range(0, 40));
      cfg_valid = ($urandom % 4) == 0;
      cfg_ch    = 3'($urandom_range(0, 7));
      cfg_m     = W'(m);
      cfg_n     = (($urandom % 5) == 0) ? W'($urandom_range(0, 40)) : W'($urandom_range(0, m / 2));
      if (($urandom % 60) == 0) pause = !pause;
      step = pause && (($urandom % 3) == 0);
      @(negedge CLK96);
    end
    cfg_valid = 1'b0;
    pause     = 1'b0;
    step      = 1'b0;
    @(negedge CLK96);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
